snn_mac_scheduler: RTL and testbench

- Sequences one 4-lane spike/weight MAC datapath over a NUM_INPUTS-wide presynaptic spike vector for one neuron.
- Per 4-input group: fetches the 128-bit weight word (four 32-bit signed lanes) from synapse weight memory, drives the external MAC with the group's 4 spike bits and that word, and reduces the four masked lanes into a saturating 32-bit accumulator.
- Sits between the neuron-update controller (start/done) and the weight SRAM plus MAC unit. Groups with no spikes are skipped without a memory read.

---
 rtl/snn_pkg.sv | 55 +++++
 rtl/snn_lane_reducer.sv | 37 +++
 rtl/snn_mac_scheduler.sv | 144 ++++++++++++++
 tb/tb_snn_mac_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_pkg
// Purpose  : Shared widths, FSM encoding and saturating accumulate for the
//            SNN spike/weight MAC scheduler.
// Revision : 1.0
// ============================================================================
package snn_pkg;

    localparam int WEIGHT_W   = 32;
    localparam int MAC_LANES  = 4;
    localparam int MAC_WORD_W = WEIGHT_W * MAC_LANES;
    // Four 32-bit lanes plus the accumulator never exceed 35 signed bits.
    localparam int SUM_W      = WEIGHT_W + 3;

    localparam logic signed [WEIGHT_W-1:0] ACC_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [WEIGHT_W-1:0] ACC_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                clip;
        logic [WEIGHT_W-1:0] value;
    } sat_res_t;

    function automatic sat_res_t sat_add(
        input logic signed [WEIGHT_W-1:0] acc,
        input logic signed [SUM_W-1:0]    grp_sum
    );
        logic signed [SUM_W-1:0] full;
        logic signed [SUM_W-1:0] wide_max;
        logic signed [SUM_W-1:0] wide_min;
        sat_res_t                res;
        wide_max  = SUM_W'(ACC_MAX);
        wide_min  = SUM_W'(ACC_MIN);
        full      = SUM_W'(acc) + grp_sum;
        res.clip  = 1'b0;
        res.value = full[WEIGHT_W-1:0];
        if (full > wide_max) begin
            res.clip  = 1'b1;
            res.value = ACC_MAX;
        end else if (full < wide_min) begin
            res.clip  = 1'b1;
            res.value = ACC_MIN;
        end
        return res;
    endfunction

endpackage : snn_pkg
`default_nettype wire

// File: rtl/snn_lane_reducer.sv
`default_nettype none
// ============================================================================
// Module   : snn_lane_reducer
// Purpose  : Combinational signed 4-lane sum added to the accumulator with
//            saturation to the 32-bit signed range.
// Revision : 1.0
// ============================================================================
module snn_lane_reducer
    import snn_pkg::*;
(
    input  logic [MAC_WORD_W-1:0] i_lanes,
    input  logic [WEIGHT_W-1:0]   i_acc,
    output logic [WEIGHT_W-1:0]   o_acc,
    output logic                  o_clip
);

    logic signed [SUM_W-1:0] w_lane [MAC_LANES];
    logic signed [SUM_W-1:0] w_grp_sum;
    sat_res_t                w_res;

    for (genvar k = 0; k < MAC_LANES; k++) begin : g_lane
        assign w_lane[k] = SUM_W'($signed(i_lanes[k*WEIGHT_W +: WEIGHT_W]));
    end

    always_comb begin
        w_grp_sum = '0;
        for (int k = 0; k < MAC_LANES; k++) begin
            w_grp_sum = w_grp_sum + w_lane[k];
        end
    end

    assign w_res  = sat_add(i_acc, w_grp_sum);
    assign o_acc  = w_res.value;
    assign o_clip = w_res.clip;

endmodule : snn_lane_reducer
`default_nettype wire

// File: rtl/snn_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : snn_mac_scheduler
// Purpose  : Walks a neuron's presynaptic spike vector in 4-input groups,
//            fetching weights for active groups and accumulating MAC output.
// Revision : 1.0
// ============================================================================
module snn_mac_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    parameter int ADDR_W     = 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_INPUTS-1:0] spike_vec,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  wt_rd_en,
    output logic [ADDR_W-1:0]     wt_addr,
    input  logic [MAC_WORD_W-1:0] wt_rdata,
    output logic [MAC_LANES-1:0]  mac_spike,
    output logic [MAC_WORD_W-1:0] mac_weight,
    input  logic [MAC_WORD_W-1:0] mac_result,
    output logic                  busy,
    output logic                  done,
    output logic [WEIGHT_W-1:0]   result,
    output logic                  sat
);

    localparam int c_num_groups = NUM_INPUTS / MAC_LANES;
    localparam int c_grp_w      = (c_num_groups > 1) ? $clog2(c_num_groups) : 1;

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_issue = ISSUE;
    localparam logic [1:0] c_st_acc   = ACC;
    localparam logic [1:0] c_st_done  = DONE;

    logic [1:0]            r_state;
    logic [NUM_INPUTS-1:0] r_spikes;
    logic [ADDR_W-1:0]     r_base;
    logic [c_grp_w-1:0]    r_grp;
    logic [WEIGHT_W-1:0]   r_acc;
    logic                  r_sat;
    logic                  r_done;
    logic [WEIGHT_W-1:0]   r_result;
    logic                  r_sat_out;

    logic [MAC_LANES-1:0]  w_nibble;
    logic                  w_last;
    logic                  w_in_acc;
    logic [WEIGHT_W-1:0]   w_red_acc;
    logic                  w_red_clip;

    always_comb begin
        w_nibble = '0;
        for (int g = 0; g < c_num_groups; g++) begin
            if (r_grp == c_grp_w'(g)) begin
                w_nibble = r_spikes[g*MAC_LANES +: MAC_LANES];
            end
        end
    end

    assign w_last   = (r_grp == c_grp_w'(c_num_groups - 1));
    assign w_in_acc = (r_state == c_st_acc);

    assign wt_rd_en   = (r_state == c_st_issue) && (w_nibble != '0);
    assign wt_addr    = wt_rd_en ? (r_base + ADDR_W'(r_grp)) : '0;
    assign mac_spike  = w_in_acc ? w_nibble : '0;
    assign mac_weight = w_in_acc ? wt_rdata : '0;
    assign busy       = (r_state != c_st_idle);
    assign done       = r_done;
    assign result     = r_result;
    assign sat        = r_sat_out;

    snn_lane_reducer u_reducer (
        .i_lanes (mac_result),
        .i_acc   (r_acc),
        .o_acc   (w_red_acc),
        .o_clip  (w_red_clip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_spikes  <= '0;
            r_base    <= '0;
            r_grp     <= '0;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_sat_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_spikes <= spike_vec;
                        r_base   <= base_addr;
                        r_acc    <= '0;
                        r_sat    <= 1'b0;
                        r_grp    <= '0;
                        r_state  <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (w_nibble != '0) begin
                        r_state <= c_st_acc;
                    end else if (w_last) begin
                        r_state   <= c_st_done;
                        r_done    <= 1'b1;
                        r_result  <= r_acc;
                        r_sat_out <= r_sat;
                    end else begin
                        r_grp <= r_grp + c_grp_w'(1);
                    end
                end
                c_st_acc: begin
                    r_acc <= w_red_acc;
                    r_sat <= r_sat | w_red_clip;
                    // The final group's sum goes straight into the result.
                    if (w_last) begin
                        r_state   <= c_st_done;
                        r_done    <= 1'b1;
                        r_result  <= w_red_acc;
                        r_sat_out <= r_sat | w_red_clip;
                    end else begin
                        r_grp   <= r_grp + c_grp_w'(1);
                        r_state <= c_st_issue;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule : snn_mac_scheduler
`default_nettype wire

// File: tb/tb_snn_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_mac_scheduler
// Purpose  : Self-checking bench with a weight-memory/MAC responder and a
//            group-by-group reference model of the accumulation.
// Revision : 1.0
// ============================================================================
module tb_snn_mac_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  spike_vec;
    logic [7:0]   base_addr;
    logic         wt_rd_en;
    logic [7:0]   wt_addr;
    logic [127:0] wt_rdata = '0;
    logic [3:0]   mac_spike;
    logic [127:0] mac_weight;
    logic [127:0] mac_result;
    logic         busy;
    logic         done;
    logic [31:0]  result;
    logic         sat;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] mem [256];
    logic [7:0]   rd_q[$];
    logic [7:0]   exp_rd_q[$];
    logic [3:0]   spk_q[$];
    logic [3:0]   exp_spk_q[$];
    int           exp_cyc;
    logic [31:0]  exp_res;
    logic         exp_sat;

    always #5 clk = ~clk;

    snn_mac_scheduler #(.NUM_INPUTS(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .spike_vec  (spike_vec),
        .base_addr  (base_addr),
        .wt_rd_en   (wt_rd_en),
        .wt_addr    (wt_addr),
        .wt_rdata   (wt_rdata),
        .mac_spike  (mac_spike),
        .mac_weight (mac_weight),
        .mac_result (mac_result),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .sat        (sat)
    );

    // Synchronous weight SRAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (wt_rd_en) wt_rdata <= mem[wt_addr];
    end

    // MAC unit: pass a lane's weight only where its spike bit is set.
    always_comb begin
        mac_result = '0;
        for (int k = 0; k < 4; k++) begin
            mac_result[32*k +: 32] = mac_spike[k] ? mac_weight[32*k +: 32] : 32'd0;
        end
    end

    task automatic set_word(input logic [7:0] a, input logic [31:0] l0, input logic [31:0] l1,
                            input logic [31:0] l2, input logic [31:0] l3);
        mem[a] = {l3, l2, l1, l0};
    endtask

    // Reference: walk groups in order, clamp the running total after each.
    task automatic model(input logic [15:0] sv, input logic [7:0] ba);
        longint acc = 0;
        bit     s   = 0;
        int     cyc = 1;
        exp_rd_q.delete();
        exp_spk_q.delete();
        for (int g = 0; g < 4; g++) begin
            logic [3:0] nib;
            logic [7:0] a;
            longint     gs;
            nib = sv[4*g +: 4];
            if (nib == 4'd0) begin
                cyc += 1;
            end else begin
                cyc += 2;
                a  = ba + 8'(g);
                exp_rd_q.push_back(a);
                exp_spk_q.push_back(nib);
                gs = 0;
                for (int k = 0; k < 4; k++) begin
                    if (nib[k]) gs += longint'($signed(mem[a][32*k +: 32]));
                end
                acc += gs;
                if (acc > 64'sd2147483647) begin
                    acc = 64'sd2147483647;
                    s   = 1;
                end else if (acc < -64'sd2147483648) begin
                    acc = -64'sd2147483648;
                    s   = 1;
                end
            end
        end
        exp_cyc = cyc;
        exp_res = acc[31:0];
        exp_sat = s;
    endtask

    function automatic bit rd_match();
        if (rd_q.size() != exp_rd_q.size()) return 0;
        foreach (rd_q[i]) if (rd_q[i] !== exp_rd_q[i]) return 0;
        return 1;
    endfunction

    function automatic bit spk_match();
        if (spk_q.size() != exp_spk_q.size()) return 0;
        foreach (spk_q[i]) if (spk_q[i] !== exp_spk_q[i]) return 0;
        return 1;
    endfunction

    // Issue one start and observe the run; optionally pulse start again at cycle pulse_cyc.
    task automatic do_run(input logic [15:0] sv, input logic [7:0] ba, input int pulse_cyc,
                          input logic [15:0] pulse_sv, output int dcyc, output logic [31:0] res,
                          output logic s, output logic post_busy);
        @(negedge clk);
        spike_vec = sv;
        base_addr = ba;
        start     = 1'b1;
        rd_q.delete();
        spk_q.delete();
        dcyc = -1;
        res  = '0;
        s    = 1'b0;
        for (int c = 1; c <= 200 && dcyc < 0; c++) begin
            @(negedge clk);
            if (wt_rd_en) rd_q.push_back(wt_addr);
            if (mac_spike != 4'd0) spk_q.push_back(mac_spike);
            if (done) begin
                dcyc = c;
                res  = result;
                s    = sat;
            end
            start = (c == pulse_cyc);
            if (c == pulse_cyc) begin
                spike_vec = pulse_sv;
                base_addr = ~ba;
            end
        end
        @(negedge clk);
        post_busy = busy;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; spike_vec = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (result !== 32'd0 || sat !== 1'b0) begin n_fail++; $display("FAIL reset_result: got %h/%b want 0/0", result, sat); end
        n_tests++; if (wt_rd_en !== 1'b0 || wt_addr !== 8'd0 || mac_spike !== 4'd0 || mac_weight !== 128'd0) begin
            n_fail++; $display("FAIL reset_mem_if: got rd=%b addr=%h spk=%h want all 0", wt_rd_en, wt_addr, mac_spike);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_group();
        int dc; logic [31:0] r; logic s, pb;
        set_word(8'h10, 32'd1, 32'd2, 32'd3, 32'd4);
        do_run(16'h000F, 8'h10, -1, '0, dc, r, s, pb);
        n_tests++; if (dc !== 6) begin n_fail++; $display("FAIL single_done_cycle: got %0d want 6", dc); end
        n_tests++; if (r !== 32'd10 || s !== 1'b0) begin n_fail++; $display("FAIL single_result: got %0d/%b want 10/0", r, s); end
        n_tests++; if (rd_q.size() != 1 || rd_q[0] !== 8'h10) begin n_fail++; $display("FAIL single_reads: got %0d reads want 1 at 0x10", rd_q.size()); end
    endtask

    task automatic test_spread();
        int dc; logic [31:0] r; logic s, pb;
        logic [3:0] want [4];
        bit ok;
        want = '{4'h1, 4'h2, 4'h4, 4'h8};
        for (int a = 0; a < 4; a++) set_word(8'(a), 32'd100, 32'd200, 32'd300, 32'd400);
        do_run(16'h8421, 8'h00, -1, '0, dc, r, s, pb);
        n_tests++; if (dc !== 9) begin n_fail++; $display("FAIL spread_done_cycle: got %0d want 9", dc); end
        n_tests++; if (r !== 32'd1000 || s !== 1'b0) begin n_fail++; $display("FAIL spread_result: got %0d/%b want 1000/0", r, s); end
        ok = (rd_q.size() == 4) && (spk_q.size() == 4);
        for (int i = 0; i < 4 && ok; i++) ok = (rd_q[i] === 8'(i)) && (spk_q[i] === want[i]);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL spread_sequence: got %0d reads/%0d nibbles want 4/4 in order", rd_q.size(), spk_q.size()); end
    endtask

    task automatic test_saturation();
        int dc; logic [31:0] r; logic s, pb;
        for (int a = 0; a < 4; a++) set_word(8'(a), 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        do_run(16'hFFFF, 8'h00, -1, '0, dc, r, s, pb);
        n_tests++; if (r !== 32'h7FFFFFFF || s !== 1'b1) begin n_fail++; $display("FAIL sat_pos: got %h/%b want 7fffffff/1", r, s); end
        for (int a = 0; a < 4; a++) set_word(8'(a), 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
        do_run(16'hFFFF, 8'h00, -1, '0, dc, r, s, pb);
        n_tests++; if (r !== 32'h80000000 || s !== 1'b1) begin n_fail++; $display("FAIL sat_neg: got %h/%b want 80000000/1", r, s); end
    endtask

    task automatic test_negative();
        int dc; logic [31:0] r; logic s, pb;
        set_word(8'h40, 32'hFFFFFFFB, 32'd7, 32'd9, 32'd9);
        do_run(16'h0003, 8'h40, -1, '0, dc, r, s, pb);
        n_tests++; if (r !== 32'd2 || s !== 1'b0) begin n_fail++; $display("FAIL negative_result: got %0d/%b want 2/0", r, s); end
    endtask

    task automatic test_zero_and_busy_start();
        int dc; logic [31:0] r; logic s, pb;
        do_run(16'h0000, 8'h33, -1, '0, dc, r, s, pb);
        n_tests++; if (dc !== 5 || r !== 32'd0) begin n_fail++; $display("FAIL zero_run: got cycle %0d result %0d want 5/0", dc, r); end
        n_tests++; if (rd_q.size() != 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", rd_q.size()); end
        // A start pulse mid-run must not disturb the running accumulation.
        for (int a = 0; a < 4; a++) set_word(8'h50 + 8'(a), 32'd11, 32'hFFFFFFF0, 32'd5, 32'd1000);
        model(16'h0F35, 8'h50);
        do_run(16'h0F35, 8'h50, 3, 16'hFFFF, dc, r, s, pb);
        n_tests++; if (r !== exp_res || dc !== exp_cyc) begin n_fail++; $display("FAIL busy_start: got %0d@%0d want %0d@%0d", $signed(r), dc, $signed(exp_res), exp_cyc); end
        // Start in the done cycle itself is ignored.
        model(16'h00F0, 8'h50);
        do_run(16'h00F0, 8'h50, exp_cyc, 16'h1111, dc, r, s, pb);
        n_tests++; if (pb !== 1'b0) begin n_fail++; $display("FAIL done_cycle_start: got busy %b want 0", pb); end
    endtask

    task automatic test_wrap();
        int dc; logic [31:0] r; logic s, pb;
        set_word(8'hFE, 32'd1, 32'd1, 32'd1, 32'd1);
        set_word(8'h00, 32'd2, 32'd2, 32'd2, 32'd2);
        do_run(16'h0F0F, 8'hFE, -1, '0, dc, r, s, pb);
        n_tests++; if (rd_q.size() != 2 || rd_q[0] !== 8'hFE || rd_q[1] !== 8'h00) begin
            n_fail++; $display("FAIL wrap_reads: got %0d reads want FE,00", rd_q.size());
        end
        n_tests++; if (r !== 32'd12) begin n_fail++; $display("FAIL wrap_result: got %0d want 12", r); end
    endtask

    task automatic test_reset_mid_run();
        int dc; logic [31:0] r; logic s, pb;
        bit seen;
        for (int a = 0; a < 4; a++) set_word(8'h20 + 8'(a), 32'd3, 32'd5, 32'd7, 32'd9);
        @(negedge clk);
        spike_vec = 16'h00FF; base_addr = 8'h20; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2) begin
                n_tests++; if (mac_spike !== 4'hF) begin n_fail++; $display("FAIL midrst_acc: got %h want f", mac_spike); end
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || wt_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got busy=%b done=%b result=%h want 0", busy, done, result);
        end
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL midrst_no_done: got activity 1 want 0"); end
        model(16'h00FF, 8'h20);
        do_run(16'h00FF, 8'h20, -1, '0, dc, r, s, pb);
        n_tests++; if (r !== exp_res || dc !== exp_cyc) begin n_fail++; $display("FAIL midrst_rerun: got %0d@%0d want %0d@%0d", r, dc, exp_res, exp_cyc); end
    endtask

    task automatic test_random();
        int dc; logic [31:0] r; logic s, pb;
        for (int it = 0; it < 24; it++) begin
            logic [15:0] sv;
            logic [7:0]  ba;
            bit          full;
            full = (it % 3 == 0);
            for (int a = 0; a < 256; a++) begin
                for (int k = 0; k < 4; k++) begin
                    mem[a][32*k +: 32] = full ? $urandom : ($urandom_range(0, 4000) - 2000);
                end
            end
            sv = 16'($urandom & $urandom);
            ba = 8'($urandom);
            model(sv, ba);
            do_run(sv, ba, -1, '0, dc, r, s, pb);
            n_tests++; if (r !== exp_res || s !== exp_sat) begin
                n_fail++; $display("FAIL rand%0d_result: got %h/%b want %h/%b", it, r, s, exp_res, exp_sat);
            end
            n_tests++; if (dc !== exp_cyc) begin n_fail++; $display("FAIL rand%0d_cycle: got %0d want %0d", it, dc, exp_cyc); end
            n_tests++; if (!rd_match() || !spk_match()) begin
                n_fail++; $display("FAIL rand%0d_reads: got %0d reads want %0d", it, rd_q.size(), exp_rd_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_spread();
        test_saturation();
        test_negative();
        test_zero_and_busy_start();
        test_wrap();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_snn_mac_scheduler
`default_nettype wire
